// File: rtl/spi_receiver.sv
// spi_receiver: oversampling SPI receiver that reassembles 8-bit MSB-first
// frames and queues complete bytes in a small FIFO.
//
// Ports:
//   clk, rst           system clock, asynchronous active-high reset
//   sclk_in, sdata_in  serial clock/data from the transmitter (asynchronous)
//   rx_data, rx_valid  FIFO head byte and not-empty flag
//   rx_ready           consumer accepts the head byte on rx_valid & rx_ready
//   fifo_count         number of stored bytes
//   overflow           sticky: a completed byte was dropped (FIFO full)
//   clr_overflow       one-cycle pulse that clears overflow
//   frame_error        one-cycle pulse when a partial frame times out
module spi_receiver #(
  parameter int DEPTH        = 4,
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sclk_in,
  input  logic                     sdata_in,
  output logic [7:0]               rx_data,
  output logic                     rx_valid,
  input  logic                     rx_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  input  logic                     clr_overflow,
  output logic                     frame_error
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(IDLE_TIMEOUT);
  localparam logic [TW-1:0] T_LAST = TW'(IDLE_TIMEOUT - 1);

  typedef enum logic {
    IDLE,
    RECV
  } state_t;

  state_t state, state_nx;

  logic sclk_s1, sclk_s2, sclk_s3;
  logic sd_s1, sd_s2;
  logic rise;

  logic [2:0]    bit_cnt, bit_nx;
  logic [7:0]    shreg, sh_nx;
  logic [TW-1:0] timer, tmr_nx;
  logic          frame_done;
  logic          timeout;
  logic [7:0]    rx_byte;

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        empty, full;
  logic        push, pop;
  logic        ovf_set;

  // Two-flop synchronizers; the third sclk flop is only for edge detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_s3 <= 1'b0;
      sd_s1   <= 1'b0;
      sd_s2   <= 1'b0;
    end else begin
      sclk_s1 <= sclk_in;
      sclk_s2 <= sclk_s1;
      sclk_s3 <= sclk_s2;
      sd_s1   <= sdata_in;
      sd_s2   <= sd_s1;
    end
  end

  assign rise    = sclk_s2 & ~sclk_s3;
  assign rx_byte = {shreg[6:0], sd_s2};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= 3'd0;
      shreg   <= 8'h00;
      timer   <= '0;
    end else begin
      state   <= state_nx;
      bit_cnt <= bit_nx;
      shreg   <= sh_nx;
      timer   <= tmr_nx;
    end
  end

  // An edge in the timeout cycle takes priority over the timeout.
  always_comb begin
    state_nx   = state;
    bit_nx     = bit_cnt;
    sh_nx      = shreg;
    tmr_nx     = timer;
    frame_done = 1'b0;
    timeout    = 1'b0;
    unique case (state)
      IDLE: begin
        tmr_nx = '0;
        if (rise) begin
          sh_nx    = rx_byte;
          bit_nx   = 3'd1;
          state_nx = RECV;
        end
      end
      RECV: begin
        if (rise) begin
          sh_nx  = rx_byte;
          bit_nx = bit_cnt + 3'd1;
          tmr_nx = '0;
          if (bit_cnt == 3'd7) begin
            frame_done = 1'b1;
            state_nx   = IDLE;
          end
        end else if (timer == T_LAST) begin
          timeout  = 1'b1;
          bit_nx   = 3'd0;
          sh_nx    = 8'h00;
          tmr_nx   = '0;
          state_nx = IDLE;
        end else begin
          tmr_nx = timer + TW'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        bit_nx   = 3'd0;
        tmr_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) frame_error <= 1'b0;
    else     frame_error <= timeout;
  end

  // FIFO: pointers carry one wrap bit above the address.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                 (wr_ptr[AW] != rd_ptr[AW]);

  assign rx_valid   = ~empty;
  assign pop        = rx_valid & rx_ready;
  assign push       = frame_done & (~full | pop);
  assign ovf_set    = frame_done & full & ~pop;
  assign fifo_count = wr_ptr - rd_ptr;
  assign rx_data    = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= rx_byte;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               overflow <= 1'b0;
    else if (ovf_set)      overflow <= 1'b1;
    else if (clr_overflow) overflow <= 1'b0;
  end

endmodule

// File: tb/tb_spi_receiver.sv
// tb_spi_receiver: randomized self-checking bench for spi_receiver,
// checked against a byte-queue reference model.
module tb_spi_receiver;

  localparam int DEPTH = 4;
  localparam int TMO   = 1024;

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk_in, sdata_in;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready;
  logic [2:0] fifo_count;
  logic       overflow, clr_overflow, frame_error;

  int n_chk  = 0;
  int n_pass = 0;
  int fe_cnt = 0;

  logic [7:0] q[$];
  logic       ovf_m;

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_error) fe_cnt++;

  spi_receiver #(.DEPTH(DEPTH), .IDLE_TIMEOUT(TMO)) dut (
    .clk(clk),
    .rst(rst),
    .sclk_in(sclk_in),
    .sdata_in(sdata_in),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .fifo_count(fifo_count),
    .overflow(overflow),
    .clr_overflow(clr_overflow),
    .frame_error(frame_error)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  // pop_last raises rx_ready for exactly the cycle the edge is consumed.
  task automatic send_bit(input logic b, input bit pop_last);
    sdata_in = b;
    repeat (4) @(negedge clk);
    sclk_in = 1'b1;
    if (pop_last) begin
      @(negedge clk);
      @(negedge clk);
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      @(negedge clk);
    end else begin
      repeat (4) @(negedge clk);
    end
    sclk_in = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit pop_last);
    for (int i = 7; i >= 0; i--)
      send_bit(b[i], pop_last && i == 0);
    if (pop_last) begin
      void'(q.pop_front());
      q.push_back(b);
    end else if (q.size() < DEPTH) begin
      q.push_back(b);
    end else begin
      ovf_m = 1'b1;
    end
  endtask

  task automatic drain_all(input string tag);
    rx_ready = 1'b1;
    while (q.size() > 0) begin
      check({tag, "_valid"}, rx_valid, 1);
      check({tag, "_data"}, rx_data, q.pop_front());
      @(negedge clk);
    end
    rx_ready = 1'b0;
    check({tag, "_empty"}, rx_valid, 0);
    check({tag, "_cnt0"}, fifo_count, 0);
  endtask

  task automatic clr_ovf();
    clr_overflow = 1'b1;
    @(negedge clk);
    clr_overflow = 1'b0;
    ovf_m = 1'b0;
    check("ovf_clr", overflow, 0);
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] burst [4];
    int fe0;
    int n;
    burst[0] = 8'h01;
    burst[1] = 8'h80;
    burst[2] = 8'hFF;
    burst[3] = 8'h3C;
    ovf_m = 1'b0;
    rst = 1'b1;
    sclk_in = 1'b0;
    sdata_in = 1'b0;
    rx_ready = 1'b0;
    clr_overflow = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", rx_valid, 0);
    check("rst_data", rx_data, 8'h00);
    check("rst_cnt", fifo_count, 0);
    check("rst_ovf", overflow, 0);
    check("rst_fe", frame_error, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single byte.
    send_byte(8'hAA, 0);
    check("single_valid", rx_valid, 1);
    check("single_data", rx_data, 8'hAA);
    check("single_cnt", fifo_count, 1);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    void'(q.pop_front());
    check("single_pop_valid", rx_valid, 0);
    check("single_pop_cnt", fifo_count, 0);

    // Burst ordering.
    for (int i = 0; i < 4; i++) send_byte(burst[i], 0);
    check("burst_cnt", fifo_count, 4);
    drain_all("burst");

    // Overflow.
    for (int i = 0; i < 5; i++) send_byte(8'h11 + 8'(i), 0);
    check("ovf_set", overflow, ovf_m);
    check("ovf_cnt", fifo_count, 4);
    drain_all("ovf");
    clr_ovf();

    // Full with simultaneous pop on the 5th byte.
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 0);
    send_byte(8'hE7, 1);
    check("fullpop_ovf", overflow, 0);
    check("fullpop_cnt", fifo_count, 4);
    check("fullpop_tail", q[3], 8'hE7);
    drain_all("fullpop");

    // Timeout of a 3-bit partial frame.
    fe0 = fe_cnt;
    send_bit(1'b1, 0);
    send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    repeat (TMO + 10) @(negedge clk);
    check("tmo_fe_pulses", fe_cnt - fe0, 1);
    check("tmo_cnt", fifo_count, 0);
    fe0 = fe_cnt;
    send_byte(8'h5A, 0);
    check("tmo_next_data", rx_data, 8'h5A);
    check("tmo_next_nofe", fe_cnt - fe0, 0);
    drain_all("tmo");

    // Randomized bursts against the queue model.
    fe0 = fe_cnt;
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) send_byte(8'($urandom), 0);
      check("rnd_cnt", fifo_count, q.size());
      check("rnd_ovf", overflow, ovf_m);
      if ($urandom_range(0, 1) == 1) begin
        drain_all("rnd");
      end else if (q.size() > 0) begin
        check("rnd_head", rx_data, q[0]);
      end
      if (ovf_m) clr_ovf();
    end
    check("rnd_nofe", fe_cnt - fe0, 0);
    drain_all("rnd_end");

    // Reset mid-frame with two bytes queued.
    send_byte(8'h42, 0);
    send_byte(8'h99, 0);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom), 0);
    fe0 = fe_cnt;
    rst = 1'b1;
    #1;
    q.delete();
    check("mrst_valid", rx_valid, 0);
    check("mrst_data", rx_data, 8'h00);
    check("mrst_cnt", fifo_count, 0);
    check("mrst_ovf", overflow, 0);
    check("mrst_fe", frame_error, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    send_byte(8'hC3, 0);
    check("mrst_c3_cnt", fifo_count, 1);
    check("mrst_c3_data", rx_data, 8'hC3);
    repeat (TMO + 10) @(negedge clk);
    check("mrst_nofe", fe_cnt - fe0, 0);
    drain_all("mrst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
